e2prom_bist: RTL and testbench
==============================

Name: e2prom_bist

Overview:
Parametrised EEPROM built-in self-test controller driving the existing byte-level I2C master (exec/done/ack handshake). On a start pulse it writes a configurable address window with a selectable data pattern, then reads the window back and verifies it. It generalises the fixed 256-byte incrementing test with a runtime base and length, several patterns, NACK retry, an optional read-only mode and error reporting. It sits between the PS/debug control registers and the I2C master.

Parameters:
WR_WAIT_CYCLES, 14'd12000, clk cycles to wait before each write and after the last write (EEPROM tWR)
MAX_RETRY, 2, extra attempts after a NACK on one byte (total attempts = MAX_RETRY+1)
ERR_CNT_W, 16, width of the error counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
start  in  1  one-cycle start request; ignored while busy
mode  in  2  pattern: 0 = seed+index, 1 = ~addr[7:0], 2 = LFSR, 3 = constant seed
skip_write  in  1  1 = skip the write phase and only verify
stop_on_err  in  1  1 = abort at the first error
base_addr  in  16  first EEPROM address
byte_cnt  in  16  number of bytes; 0 is legal
seed  in  8  pattern seed
i2c_rh_wl  out  1  1 = read, 0 = write
i2c_exec  out  1  one-cycle transaction request
i2c_addr  out  16  transaction address
i2c_data_w  out  8  write data
i2c_data_r  in  8  read data, valid with i2c_done
i2c_done  in  1  one-cycle transaction completion
i2c_ack  in  1  1 = NACK/failure at completion
busy  out  1  test in progress
done  out  1  one-cycle completion pulse
pass  out  1  result, held until the next accepted start
err_cnt  out  ERR_CNT_W  number of failing bytes, saturating
first_err_addr  out  16  address of the first failing byte
first_err_data  out  8  data read at the first failure (8'h00 if the failure was a NACK)

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- Start acceptance:
  - In IDLE, start=1 latches mode, skip_write, stop_on_err, base_addr, byte_cnt and seed.
  - Clears err_cnt, first_err_*, pass and index. busy=1 from the next cycle.
- States: IDLE -> WR_WAIT -> WR_EXEC -> WR_BUSY -> (loop to WR_WAIT) -> RD_EXEC -> RD_BUSY -> (loop to RD_EXEC) -> FINISH -> IDLE.
- byte_cnt=0: go directly to FINISH; pass=1, err_cnt=0.
- skip_write=1: enter RD_EXEC directly.
- Address and pattern:
  - i2c_addr = base_addr + index, modulo 2^16; wraps FFFF -> 0000.
  - mode 0: data = seed + index[7:0], mod 256.
  - mode 1: data = ~addr[7:0].
  - mode 3: data = seed.
  - mode 2 (LFSR): lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}. Loaded with seed, or 8'h01 if seed=0. Advanced once per byte; reloaded at the start of the read phase.
- WR_WAIT: count WR_WAIT_CYCLES cycles, then go to WR_EXEC. i2c_rh_wl=0.
- WR_EXEC: i2c_exec=1 for exactly 1 cycle, with i2c_addr/i2c_data_w stable; go to WR_BUSY. Address and data stay stable until i2c_done.
- WR_BUSY, on i2c_done:
  - ack=0: index++. If index reaches byte_cnt, do a final WR_WAIT, then the read phase. Otherwise go to WR_WAIT.
  - ack=1 with retries left: retry counter++; back to WR_WAIT for the same byte.
  - ack=1 with retries exhausted: log an error (see Error logging); advance to the next byte, or go to FINISH if stop_on_err=1.
- Read phase: index restarts at 0; i2c_rh_wl=1. RD_EXEC pulses i2c_exec for 1 cycle (back-to-back, no wait); then RD_BUSY.
- RD_BUSY, on i2c_done:
  - NACK: retry as in the write phase.
  - Otherwise compare i2c_data_r with the expected pattern. A mismatch is an error.
  - Then advance; after the last byte go to FINISH.
- Error logging:
  - err_cnt increments and saturates at all-ones.
  - first_err_addr/first_err_data are captured only when err_cnt was 0.
  - stop_on_err=1: the first error goes to FINISH.
- FINISH: pass = (err_cnt==0); done=1 for 1 cycle; busy=0 in the same cycle; return to IDLE.
- Ignored inputs: i2c_done is ignored outside WR_BUSY/RD_BUSY; start is ignored unless in IDLE.
- Reset mid-test aborts immediately to the reset state. An I2C transaction already in flight is the master's concern.

Test Plan:
- Pass run: WR_WAIT_CYCLES=10, behavioral EEPROM model, mode 0, seed 8'h10, base 16'h0020, cnt 4 -> writes 10,11,12,13 to 0020..0023; 4 reads; done pulse; pass=1; err_cnt=0.
- LFSR: mode 2, seed 0, cnt 5 -> written data 01,02,04,08,11; verify passes.
- Address wrap: base 16'hFFFE, cnt 4, mode 1 -> addresses FFFE,FFFF,0000,0001 with data 01,00,FF,FE.
- NACK retry: model NACKs the first two writes to one address, MAX_RETRY=2 -> 3 exec pulses to that address, pass=1. NACK all 3 attempts -> err_cnt=1, first_err_addr=that address, first_err_data=00.
- Corrupted byte: model corrupts the byte at index 1 (read 8'hAA).
  - stop_on_err=0 -> all bytes read, err_cnt=1, first_err_data=AA, pass=0.
  - stop_on_err=1 -> done right after the index-1 read; no further exec pulses.
- Edge cases:
  - byte_cnt=0 -> done 2 cycles after start, no i2c_exec, pass=1.
  - start while busy -> ignored.
  - rst_n low mid-write -> all outputs 0.

Source files
------------

// File: rtl/e2prom_bist.sv
// EEPROM built-in self-test: writes a pattern over an address window
// through the byte-level I2C master, then reads it back and verifies it.
module e2prom_bist #(
  parameter logic [13:0] WR_WAIT_CYCLES = 14'd12000,
  parameter int          MAX_RETRY      = 2,
  parameter int          ERR_CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic                 skip_write,
  input  logic                 stop_on_err,
  input  logic [15:0]          base_addr,
  input  logic [15:0]          byte_cnt,
  input  logic [7:0]           seed,
  output logic                 i2c_rh_wl,
  output logic                 i2c_exec,
  output logic [15:0]          i2c_addr,
  output logic [7:0]           i2c_data_w,
  input  logic [7:0]           i2c_data_r,
  input  logic                 i2c_done,
  input  logic                 i2c_ack,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [15:0]          first_err_addr,
  output logic [7:0]           first_err_data
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE,
    WR_WAIT,
    WR_EXEC,
    WR_BUSY,
    RD_EXEC,
    RD_BUSY,
    FINISH
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             mode_q, mode_d;
  logic                   stop_q, stop_d;
  logic [15:0]            base_q, base_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [7:0]             seed_q, seed_d;
  logic [15:0]            idx_q, idx_d;
  logic [7:0]             lfsr_q, lfsr_d;
  logic [13:0]            wait_q, wait_d;
  logic [RW-1:0]          retry_q, retry_d;
  logic                   final_q, final_d;
  logic [ERR_CNT_W-1:0]   errc_q, errc_d;
  logic [15:0]            fea_q, fea_d;
  logic [7:0]             fed_q, fed_d;
  logic                   pass_q, pass_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;

  logic [15:0] addr;
  logic [7:0]  exp_data;
  logic [7:0]  lfsr_nxt;
  logic        last;
  logic        err;
  logic [7:0]  err_data;
  logic        adv;

  assign addr     = base_q + idx_q;
  assign lfsr_nxt = {lfsr_q[6:0],
                     lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign last     = ((idx_q + 16'd1) == cnt_q);

  always_comb begin
    exp_data = seed_q;
    unique case (mode_q)
      2'd0: exp_data = seed_q + idx_q[7:0];
      2'd1: exp_data = ~addr[7:0];
      2'd2: exp_data = lfsr_q;
      2'd3: exp_data = seed_q;
      default: exp_data = seed_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    stop_d   = stop_q;
    base_d   = base_q;
    cnt_d    = cnt_q;
    seed_d   = seed_q;
    idx_d    = idx_q;
    lfsr_d   = lfsr_q;
    wait_d   = wait_q;
    retry_d  = retry_q;
    final_d  = final_q;
    errc_d   = errc_q;
    fea_d    = fea_q;
    fed_d    = fed_q;
    pass_d   = pass_q;
    done_d   = 1'b0;
    err      = 1'b0;
    err_data = 8'h00;
    adv      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode;
          stop_d  = stop_on_err;
          base_d  = base_addr;
          cnt_d   = byte_cnt;
          seed_d  = seed;
          idx_d   = 16'd0;
          lfsr_d  = (seed == 8'h00) ? 8'h01 : seed;
          wait_d  = 14'd0;
          retry_d = '0;
          final_d = 1'b0;
          errc_d  = '0;
          fea_d   = 16'd0;
          fed_d   = 8'h00;
          pass_d  = 1'b0;
          if (byte_cnt == 16'd0) state_d = FINISH;
          else if (skip_write)   state_d = RD_EXEC;
          else                   state_d = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if ((wait_q + 14'd1) >= WR_WAIT_CYCLES) begin
          wait_d = 14'd0;
          if (final_q) begin
            // write phase done: rewind for verification
            final_d = 1'b0;
            idx_d   = 16'd0;
            retry_d = '0;
            lfsr_d  = (seed_q == 8'h00) ? 8'h01 : seed_q;
            state_d = RD_EXEC;
          end else begin
            state_d = WR_EXEC;
          end
        end else begin
          wait_d = wait_q + 14'd1;
        end
      end
      WR_EXEC: state_d = WR_BUSY;
      WR_BUSY: begin
        if (i2c_done) begin
          if (!i2c_ack) begin
            adv = 1'b1;
          end else if (retry_q != RETRY_MAX) begin
            retry_d = retry_q + 1'b1;
            state_d = WR_WAIT;
          end else begin
            err = 1'b1;
            adv = 1'b1;
          end
        end
      end
      RD_EXEC: state_d = RD_BUSY;
      RD_BUSY: begin
        if (i2c_done) begin
          if (i2c_ack && retry_q != RETRY_MAX) begin
            retry_d = retry_q + 1'b1;
            state_d = RD_EXEC;
          end else if (i2c_ack) begin
            err = 1'b1;
            adv = 1'b1;
          end else begin
            err      = (i2c_data_r != exp_data);
            err_data = i2c_data_r;
            adv      = 1'b1;
          end
        end
      end
      FINISH: begin
        pass_d  = (errc_q == '0);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (err) begin
      if (errc_q == '0) begin
        fea_d = addr;
        fed_d = err_data;
      end
      if (errc_q != '1) errc_d = errc_q + 1'b1;
    end

    if (adv) begin
      idx_d   = idx_q + 16'd1;
      retry_d = '0;
      lfsr_d  = lfsr_nxt;
      if (err && stop_q) begin
        state_d = FINISH;
      end else if (state_q == WR_BUSY) begin
        state_d = WR_WAIT;
        final_d = last;
      end else begin
        state_d = last ? FINISH : RD_EXEC;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= 2'd0;
      stop_q  <= 1'b0;
      base_q  <= 16'd0;
      cnt_q   <= 16'd0;
      seed_q  <= 8'h00;
      idx_q   <= 16'd0;
      lfsr_q  <= 8'h00;
      wait_q  <= 14'd0;
      retry_q <= '0;
      final_q <= 1'b0;
      errc_q  <= '0;
      fea_q   <= 16'd0;
      fed_q   <= 8'h00;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      stop_q  <= stop_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      seed_q  <= seed_d;
      idx_q   <= idx_d;
      lfsr_q  <= lfsr_d;
      wait_q  <= wait_d;
      retry_q <= retry_d;
      final_q <= final_d;
      errc_q  <= errc_d;
      fea_q   <= fea_d;
      fed_q   <= fed_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign i2c_exec       = (state_q == WR_EXEC) || (state_q == RD_EXEC);
  assign i2c_rh_wl      = (state_q == RD_EXEC) || (state_q == RD_BUSY);
  assign i2c_addr       = addr;
  assign i2c_data_w     = exp_data;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = errc_q;
  assign first_err_addr = fea_q;
  assign first_err_data = fed_q;

endmodule

// File: tb/tb_e2prom_bist.sv
// Directed bench for e2prom_bist with a behavioural EEPROM behind
// the I2C handshake (NACK injection and read corruption).
module tb_e2prom_bist;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        skip_write = 1'b0;
  logic        stop_on_err = 1'b0;
  logic [15:0] base_addr = 16'd0;
  logic [15:0] byte_cnt = 16'd0;
  logic [7:0]  seed = 8'h00;
  logic        i2c_rh_wl;
  logic        i2c_exec;
  logic [15:0] i2c_addr;
  logic [7:0]  i2c_data_w;
  logic [7:0]  i2c_data_r = 8'h00;
  logic        i2c_done = 1'b0;
  logic        i2c_ack = 1'b0;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_cnt;
  logic [15:0] first_err_addr;
  logic [7:0]  first_err_data;

  e2prom_bist #(
    .WR_WAIT_CYCLES(14'd10),
    .MAX_RETRY(2),
    .ERR_CNT_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .mode(mode),
    .skip_write(skip_write),
    .stop_on_err(stop_on_err),
    .base_addr(base_addr),
    .byte_cnt(byte_cnt),
    .seed(seed),
    .i2c_rh_wl(i2c_rh_wl),
    .i2c_exec(i2c_exec),
    .i2c_addr(i2c_addr),
    .i2c_data_w(i2c_data_w),
    .i2c_data_r(i2c_data_r),
    .i2c_done(i2c_done),
    .i2c_ack(i2c_ack),
    .busy(busy),
    .done(done),
    .pass(pass),
    .err_cnt(err_cnt),
    .first_err_addr(first_err_addr),
    .first_err_data(first_err_data)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // behavioural EEPROM
  logic [7:0]  mem [int];
  int          nack_addr = -1;
  int          nack_left = 0;
  int          corrupt_addr = -1;
  logic        m_pend = 1'b0;
  int          m_lat = 0;
  logic [15:0] m_a = 16'd0;
  logic [7:0]  m_d = 8'h00;
  logic        m_rw = 1'b0;
  int          n_exec = 0;
  int          n_nack_ex = 0;
  int          n_wr = 0;
  int          n_rd = 0;
  logic [15:0] wlog_a [16];
  logic [7:0]  wlog_d [16];

  always @(negedge clk) begin
    i2c_done = 1'b0;
    i2c_ack  = 1'b0;
    if (m_pend) begin
      if (m_lat != 0) begin
        m_lat--;
      end else begin
        m_pend   = 1'b0;
        i2c_done = 1'b1;
        if (!m_rw && int'(m_a) == nack_addr && nack_left > 0) begin
          i2c_ack = 1'b1;
          nack_left--;
        end else if (!m_rw) begin
          mem[int'(m_a)] = m_d;
          if (n_wr < 16) begin
            wlog_a[n_wr] = m_a;
            wlog_d[n_wr] = m_d;
          end
          n_wr++;
        end else begin
          n_rd++;
          if (int'(m_a) == corrupt_addr) i2c_data_r = 8'hAA;
          else if (mem.exists(int'(m_a))) i2c_data_r = mem[int'(m_a)];
          else i2c_data_r = 8'h00;
        end
      end
    end
    if (i2c_exec) begin
      m_pend = 1'b1;
      m_lat  = 2;
      m_a    = i2c_addr;
      m_d    = i2c_data_w;
      m_rw   = i2c_rh_wl;
      n_exec++;
      if (!i2c_rh_wl && int'(i2c_addr) == nack_addr) n_nack_ex++;
    end
  end

  int cyc;
  logic seen;

  task automatic run(input logic [1:0] m, input logic sk,
                     input logic st, input logic [15:0] b,
                     input logic [15:0] c, input logic [7:0] s,
                     input int poke);
    n_exec    = 0;
    n_nack_ex = 0;
    n_wr      = 0;
    n_rd      = 0;
    @(negedge clk);
    mode        = m;
    skip_write  = sk;
    stop_on_err = st;
    base_addr   = b;
    byte_cnt    = c;
    seed        = s;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    seen  = 1'b0;
    while (cyc < 3000 && !seen) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (cyc == poke) begin
          byte_cnt = 16'd0;
          start    = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        cyc++;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    chk("rst_fea", 32'(first_err_addr), 32'd0);
    chk("rst_exec", 32'(i2c_exec), 32'd0);
    chk("rst_addr", 32'(i2c_addr), 32'd0);
    rst_n = 1'b1;

    // incrementing pattern
    run(2'd0, 1'b0, 1'b0, 16'h0020, 16'd4, 8'h10, 0);
    chk("p0_pass", 32'(pass), 32'd1);
    chk("p0_err", 32'(err_cnt), 32'd0);
    chk("p0_nwr", n_wr, 4);
    chk("p0_nrd", n_rd, 4);
    chk("p0_a0", 32'(wlog_a[0]), 32'h0020);
    chk("p0_d0", 32'(wlog_d[0]), 32'h10);
    chk("p0_a3", 32'(wlog_a[3]), 32'h0023);
    chk("p0_d3", 32'(wlog_d[3]), 32'h13);
    @(negedge clk);
    chk("p0_done_pulse", 32'(done), 32'd0);
    chk("p0_busy_idle", 32'(busy), 32'd0);

    // LFSR from seed 0
    run(2'd2, 1'b0, 1'b0, 16'h0100, 16'd5, 8'h00, 0);
    chk("lfsr_d", {wlog_d[0], wlog_d[1], wlog_d[2], wlog_d[3]},
        32'h01020408);
    chk("lfsr_d4", 32'(wlog_d[4]), 32'h11);
    chk("lfsr_pass", 32'(pass), 32'd1);

    // address wrap with ~addr pattern
    run(2'd1, 1'b0, 1'b0, 16'hFFFE, 16'd4, 8'h00, 0);
    chk("wrap_a", {wlog_a[0], wlog_a[1]}, 32'hFFFEFFFF);
    chk("wrap_a2", {wlog_a[2], wlog_a[3]}, 32'h00000001);
    chk("wrap_d", {wlog_d[0], wlog_d[1], wlog_d[2], wlog_d[3]},
        32'h0100FFFE);
    chk("wrap_pass", 32'(pass), 32'd1);

    // two NACKs then success
    nack_addr = 16'h0201;
    nack_left = 2;
    run(2'd3, 1'b0, 1'b0, 16'h0200, 16'd4, 8'h5A, 0);
    chk("nack2_execs", n_nack_ex, 3);
    chk("nack2_pass", 32'(pass), 32'd1);
    chk("nack2_err", 32'(err_cnt), 32'd0);

    // NACK on all attempts
    nack_left = 3;
    run(2'd3, 1'b0, 1'b0, 16'h0200, 16'd4, 8'h5A, 0);
    chk("nack3_execs", n_nack_ex, 3);
    chk("nack3_err", 32'(err_cnt), 32'd1);
    chk("nack3_fea", 32'(first_err_addr), 32'h0201);
    chk("nack3_fed", 32'(first_err_data), 32'h00);
    chk("nack3_pass", 32'(pass), 32'd0);
    nack_addr = -1;

    // corrupted read, keep going
    corrupt_addr = 16'h0301;
    run(2'd0, 1'b0, 1'b0, 16'h0300, 16'd4, 8'h40, 0);
    chk("cor_nrd", n_rd, 4);
    chk("cor_err", 32'(err_cnt), 32'd1);
    chk("cor_fea", 32'(first_err_addr), 32'h0301);
    chk("cor_fed", 32'(first_err_data), 32'hAA);
    chk("cor_pass", 32'(pass), 32'd0);

    // corrupted read, stop at first error (verify only)
    run(2'd0, 1'b1, 1'b1, 16'h0300, 16'd4, 8'h40, 0);
    repeat (6) @(negedge clk);
    chk("stop_nwr", n_wr, 0);
    chk("stop_nrd", n_rd, 2);
    chk("stop_exec", n_exec, 2);
    chk("stop_err", 32'(err_cnt), 32'd1);
    chk("stop_pass", 32'(pass), 32'd0);
    corrupt_addr = -1;

    // zero-length test
    run(2'd0, 1'b0, 1'b0, 16'h0500, 16'd0, 8'h00, 0);
    chk("zero_cyc", cyc, 2);
    chk("zero_exec", n_exec, 0);
    chk("zero_pass", 32'(pass), 32'd1);
    chk("zero_err", 32'(err_cnt), 32'd0);

    // start while busy must be ignored
    run(2'd3, 1'b0, 1'b0, 16'h0400, 16'd2, 8'h33, 5);
    chk("ign_nwr", n_wr, 2);
    chk("ign_a1", 32'(wlog_a[1]), 32'h0401);
    chk("ign_pass", 32'(pass), 32'd1);

    // reset in the middle of the write phase
    @(negedge clk);
    mode      = 2'd0;
    base_addr = 16'h0600;
    byte_cnt  = 16'd3;
    seed      = 8'h77;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_pass", 32'(pass), 32'd0);
    chk("mr_exec", 32'(i2c_exec), 32'd0);
    chk("mr_addr", 32'(i2c_addr), 32'd0);
    chk("mr_dw", 32'(i2c_data_w), 32'd0);
    chk("mr_rw", 32'(i2c_rh_wl), 32'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
